// File: rtl/alu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_control_unit
//  Purpose  : Fetch / decode / execute sequencer for the 8-bit accumulator
//             ALU datapath. Reads 16-bit instructions from a synchronous
//             program memory and produces the single-cycle datapath strobes
//             for each instruction, plus jump, conditional jump and halt.
//  Revision : 1.0  initial release
// ============================================================================
module alu_control_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_pm_data,
  input  logic [7:0]  i_acumulator,
  output logic [7:0]  o_pm_addr,
  output logic        o_pm_rd,
  output logic [7:0]  o_dm_addr,
  output logic        o_dm_rd,
  output logic        o_acumulator_ce,
  output logic [2:0]  o_operation_code,
  output logic [2:0]  o_register_file_ce,
  output logic [1:0]  o_register_file_mux_addr,
  output logic        o_data_memory_read_enable,
  output logic [7:0]  o_direct_data,
  output logic        o_direct_load,
  output logic        o_busy,
  output logic        o_halted
);

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  // Opcodes outside the ALU group (0x0-0x6 are ALU operations)
  localparam logic [3:0] c_op_ldi  = 4'h7;
  localparam logic [3:0] c_op_st   = 4'h8;
  localparam logic [3:0] c_op_jmp  = 4'h9;
  localparam logic [3:0] c_op_jz   = 4'hA;
  localparam logic [3:0] c_op_halt = 4'hB;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;

  logic [3:0]  w_opcode;
  logic        w_ir_is_alu;
  logic        w_ir_src_mem;
  logic        w_pm_is_alu;
  logic        w_take_jump;
  logic        w_unused_ir_bit;

  // Field extraction from the latched instruction
  assign w_opcode        = r_ir[15:12];
  assign w_ir_is_alu     = (r_ir[15] == 1'b0) && (r_ir[14:12] != 3'b111);
  assign w_ir_src_mem    = r_ir[11];
  // IR[10] carries no meaning in this instruction set
  assign w_unused_ir_bit = r_ir[10];

  // ALU classification of the word arriving from program memory in DECODE
  assign w_pm_is_alu = (i_pm_data[15] == 1'b0) && (i_pm_data[14:12] != 3'b111);

  // JMP always redirects; JZ only when the accumulator is zero during EXEC
  assign w_take_jump = (w_opcode == c_op_jmp) ||
                       ((w_opcode == c_op_jz) && (i_acumulator == 8'h00));

  // Status outputs and program address follow state and PC directly
  assign o_busy    = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign o_halted  = (r_state == S_HALTED);
  assign o_pm_addr = r_pc;

  // State register; asynchronous reset drops every strobe immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Program counter and instruction register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= 8'h00;
      r_ir <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (i_start) begin
            r_pc <= 8'h00;
          end
        end
        S_DECODE: begin
          r_ir <= i_pm_data;
          r_pc <= r_pc + 8'd1;
        end
        S_EXEC: begin
          // Jump target overrides the increment done in DECODE
          if (w_take_jump) begin
            r_pc <= r_ir[7:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state selection and per-state datapath strobes
  always_comb begin
    w_state_next              = r_state;
    o_pm_rd                   = 1'b0;
    o_dm_addr                 = 8'h00;
    o_dm_rd                   = 1'b0;
    o_acumulator_ce           = 1'b0;
    o_operation_code          = 3'b000;
    o_register_file_ce        = 3'b000;
    o_register_file_mux_addr  = 2'b00;
    o_data_memory_read_enable = 1'b0;
    o_direct_data             = 8'h00;
    o_direct_load             = 1'b0;

    case (r_state)
      S_IDLE, S_HALTED: begin
        if (i_start) begin
          w_state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        o_pm_rd      = 1'b1;
        w_state_next = S_DECODE;
      end

      S_DECODE: begin
        // Only ALU operations take an operand from data memory
        if (w_pm_is_alu && i_pm_data[11]) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_EXEC;
        end
      end

      S_MEM: begin
        o_dm_rd      = 1'b1;
        o_dm_addr    = r_ir[7:0];
        w_state_next = S_EXEC;
      end

      S_EXEC: begin
        if (w_ir_is_alu) begin
          o_acumulator_ce  = 1'b1;
          o_operation_code = r_ir[14:12];
          if (w_ir_src_mem) begin
            // Address held from MEM so the read data stays valid
            o_data_memory_read_enable = 1'b1;
            o_dm_addr                 = r_ir[7:0];
          end else begin
            o_register_file_mux_addr = r_ir[9:8];
          end
        end else if (w_opcode == c_op_ldi) begin
          o_acumulator_ce = 1'b1;
          o_direct_load   = 1'b1;
          o_direct_data   = r_ir[7:0];
        end else if (w_opcode == c_op_st) begin
          // Index 0 encodes as 000, i.e. no register is written
          o_register_file_ce = {1'b0, r_ir[9:8]};
        end

        if (w_opcode == c_op_halt) begin
          w_state_next = S_HALTED;
        end else begin
          w_state_next = S_FETCH;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_control_unit
//  Purpose  : Self-checking bench for alu_control_unit: table of single
//             instructions, hand-written multi-cycle sequences and a random
//             program run against an instruction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_control_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_pm_data;
  logic [7:0]  i_acumulator;
  logic [7:0]  o_pm_addr;
  logic        o_pm_rd;
  logic [7:0]  o_dm_addr;
  logic        o_dm_rd;
  logic        o_acumulator_ce;
  logic [2:0]  o_operation_code;
  logic [2:0]  o_register_file_ce;
  logic [1:0]  o_register_file_mux_addr;
  logic        o_data_memory_read_enable;
  logic [7:0]  o_direct_data;
  logic        o_direct_load;
  logic        o_busy;
  logic        o_halted;

  alu_control_unit dut (
    .i_clk                     (i_clk),
    .i_rst                     (i_rst),
    .i_start                   (i_start),
    .i_pm_data                 (i_pm_data),
    .i_acumulator              (i_acumulator),
    .o_pm_addr                 (o_pm_addr),
    .o_pm_rd                   (o_pm_rd),
    .o_dm_addr                 (o_dm_addr),
    .o_dm_rd                   (o_dm_rd),
    .o_acumulator_ce           (o_acumulator_ce),
    .o_operation_code          (o_operation_code),
    .o_register_file_ce        (o_register_file_ce),
    .o_register_file_mux_addr  (o_register_file_mux_addr),
    .o_data_memory_read_enable (o_data_memory_read_enable),
    .o_direct_data             (o_direct_data),
    .o_direct_load             (o_direct_load),
    .o_busy                    (o_busy),
    .o_halted                  (o_halted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Program memory with one-cycle read latency
  logic [15:0] pm [256];
  initial i_pm_data = 16'h0000;
  always @(posedge i_clk) begin
    if (o_pm_rd) i_pm_data <= pm[o_pm_addr];
  end

  // Datapath-facing strobes packed as
  // {acc_ce, op, rf_ce, mux, dm_rd, dm_addr, dmre, direct_data, direct_load}
  logic [27:0] obs;
  assign obs = {o_acumulator_ce, o_operation_code, o_register_file_ce,
                o_register_file_mux_addr, o_dm_rd, o_dm_addr,
                o_data_memory_read_enable, o_direct_data, o_direct_load};

  function automatic logic [27:0] mk(input logic ace, input logic [2:0] op,
                                     input logic [2:0] rf, input logic [1:0] mux,
                                     input logic dmrd, input logic [7:0] dma,
                                     input logic dmre, input logic [7:0] dd,
                                     input logic dl);
    return {ace, op, rf, mux, dmrd, dma, dmre, dd, dl};
  endfunction

  // Instruction-set rules: strobes expected during EXEC
  function automatic logic [27:0] exp_exec(input logic [15:0] ins);
    int opc;
    opc = int'(ins[15:12]);
    if (opc <= 6) begin
      if (ins[11]) return mk(1'b1, ins[14:12], 3'd0, 2'd0, 1'b0, ins[7:0], 1'b1, 8'h00, 1'b0);
      else         return mk(1'b1, ins[14:12], 3'd0, ins[9:8], 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    end
    if (opc == 7) return mk(1'b1, 3'd0, 3'd0, 2'd0, 1'b0, 8'h00, 1'b0, ins[7:0], 1'b1);
    if (opc == 8) return mk(1'b0, 3'd0, {1'b0, ins[9:8]}, 2'd0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    return 28'd0;
  endfunction

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_start = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) pm[a] = 16'hB000;
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  acc;
    int          lat;
    logic [27:0] exp;
    logic        halt;
    logic [7:0]  next;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [15:0] ins;
    logic [7:0]  mpc;
    logic [7:0]  acc;

    i_rst = 1'b1;
    i_start = 1'b0;
    i_acumulator = 8'h00;
    fill_halt();

    vt[0]  = '{16'h7005, 8'h11, 3, mk(1,0,0,0,0,8'h00,0,8'h05,1), 1'b0, 8'h01};
    vt[1]  = '{16'h8100, 8'h11, 3, mk(0,0,3'b001,0,0,8'h00,0,8'h00,0), 1'b0, 8'h01};
    vt[2]  = '{16'h0100, 8'h11, 3, mk(1,0,0,2'b01,0,8'h00,0,8'h00,0), 1'b0, 8'h01};
    vt[3]  = '{16'h0842, 8'h11, 4, mk(1,0,0,0,0,8'h42,1,8'h00,0), 1'b0, 8'h01};
    vt[4]  = '{16'h5300, 8'h11, 3, mk(1,3'd5,0,2'b11,0,8'h00,0,8'h00,0), 1'b0, 8'h01};
    vt[5]  = '{16'h8000, 8'h11, 3, 28'd0, 1'b0, 8'h01};
    vt[6]  = '{16'hA010, 8'h00, 3, 28'd0, 1'b0, 8'h10};
    vt[7]  = '{16'hA010, 8'h03, 3, 28'd0, 1'b0, 8'h01};
    vt[8]  = '{16'h90FF, 8'h11, 3, 28'd0, 1'b0, 8'hFF};
    vt[9]  = '{16'hC000, 8'h11, 3, 28'd0, 1'b0, 8'h01};
    vt[10] = '{16'hB000, 8'h11, 3, 28'd0, 1'b1, 8'h00};
    vt[11] = '{16'h6A77, 8'h11, 4, mk(1,3'd6,0,0,0,8'h77,1,8'h00,0), 1'b0, 8'h01};
    vt[12] = '{16'h7AFF, 8'h11, 3, mk(1,0,0,0,0,8'h00,0,8'hFF,1), 1'b0, 8'h01};

    // Reset state: every output zero
    tick();
    chk("reset_outputs", {o_pm_rd, o_pm_addr, o_busy, o_halted, obs}, 40'd0);
    i_rst = 1'b0;

    // Single-instruction table
    foreach (vt[i]) begin
      do_reset();
      fill_halt();
      pm[0] = vt[i].instr;
      i_acumulator = vt[i].acc;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk($sformatf("vec%0d_fetch", i), {o_pm_rd, o_pm_addr, o_busy}, {1'b1, 8'h00, 1'b1});
      tick();
      if (vt[i].lat == 4) begin
        tick();
        chk($sformatf("vec%0d_mem", i), obs, mk(0,0,0,0,1,vt[i].instr[7:0],0,8'h00,0));
      end
      tick();
      chk($sformatf("vec%0d_exec", i), obs, vt[i].exp);
      tick();
      if (vt[i].halt)
        chk($sformatf("vec%0d_halt", i), {o_halted, o_busy, o_pm_rd, obs}, {3'b100, 28'd0});
      else
        chk($sformatf("vec%0d_next", i), {o_pm_rd, o_pm_addr}, {1'b1, vt[i].next});
    end

    // LDI 5, ST r1, ADD r1: EXEC at cycles 3, 6, 9
    do_reset();
    fill_halt();
    pm[0] = 16'h7005; pm[1] = 16'h8100; pm[2] = 16'h0100;
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick();
    chk("seq_c3", obs, mk(1,0,0,0,0,8'h00,0,8'h05,1));
    tick(); tick(); tick();
    chk("seq_c6", obs, mk(0,0,3'b001,0,0,8'h00,0,8'h00,0));
    tick(); tick(); tick();
    chk("seq_c9", obs, mk(1,0,0,2'b01,0,8'h00,0,8'h00,0));

    // Reset asserted in the middle of LDI's EXEC
    do_reset();
    pm[0] = 16'h7005;
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick();
    chk("rst_pre_exec", {o_acumulator_ce, o_direct_load}, 2'b11);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_exec", {o_acumulator_ce, o_direct_load, o_busy}, 3'b000);
    tick();
    i_rst = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("rst_restart", {o_pm_rd, o_pm_addr}, {1'b1, 8'h00});

    // JMP 0xFF then NOP at 0xFF wraps to 0x00
    do_reset();
    fill_halt();
    pm[0] = 16'h90FF; pm[255] = 16'hC000;
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick(); tick();
    chk("wrap_fetch_ff", {o_pm_rd, o_pm_addr}, {1'b1, 8'hFF});
    tick(); tick(); tick();
    chk("wrap_fetch_00", {o_pm_rd, o_pm_addr}, {1'b1, 8'h00});

    // HALT, i_start in HALTED restarts from 0 and clears o_halted
    do_reset();
    fill_halt();
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick(); tick(); tick();
    chk("halt_state", {o_halted, o_busy, o_pm_rd, obs}, {3'b100, 28'd0});
    tick();
    chk("halt_stays", {o_halted, o_busy}, 2'b10);
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk("halt_restart", {o_halted, o_busy, o_pm_rd, o_pm_addr}, {3'b011, 8'h00});

    // Random program against the instruction-level model
    do_reset();
    for (int a = 0; a < 256; a++) pm[a] = 16'($urandom);
    i_start = 1'b1; tick();
    mpc = 8'h00;
    for (int k = 0; k < 400; k++) begin
      chk("rnd_fetch", {o_pm_rd, o_pm_addr, o_busy}, {1'b1, mpc, 1'b1});
      ins = pm[mpc];
      mpc = mpc + 8'd1;
      i_start = 1'($urandom);
      tick();
      chk("rnd_decode", {o_pm_rd, obs}, 29'd0);
      if ((ins[15:12] <= 4'd6) && ins[11]) begin
        i_start = 1'($urandom);
        tick();
        chk("rnd_mem", obs, mk(0,0,0,0,1,ins[7:0],0,8'h00,0));
      end
      i_start = 1'($urandom);
      tick();
      acc = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      i_acumulator = acc;
      chk("rnd_exec", obs, exp_exec(ins));
      if (ins[15:12] == 4'h9) mpc = ins[7:0];
      if ((ins[15:12] == 4'hA) && (acc == 8'h00)) mpc = ins[7:0];
      if (ins[15:12] == 4'hB) begin
        tick();
        chk("rnd_halt", {o_halted, o_busy, o_pm_rd, obs}, {3'b100, 28'd0});
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        mpc = 8'h00;
      end else begin
        i_start = 1'($urandom);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
